butterfly_pipe: RTL and testbench
=================================

# butterfly_pipe

Parametrised, pipelined radix-2 decimation-in-time butterfly for the FFT datapath. Computes X = A + B·T and Y = A − B·T on signed two's-complement Q-format complex samples. Uses a valid/ready handshake, optional per-transaction divide-by-2 scaling, rounding and overflow reporting. It sits between the sample-memory read port and the write-back port, inside the stage sequencer, and carries a user tag (memory address) alongside the data.

## Interface
- `W`, 16: sample and twiddle width (signed two's complement), 8..24.
- `FRAC`, 8: fractional bits of the twiddle, so 1.0 = 2^FRAC; 1 ≤ FRAC < W.
- `TAG_W`, 8: width of the pass-through tag.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: block accepts input this cycle.
- `a_re`, `a_im` in W: operand A.
- `b_re`, `b_im` in W: operand B.
- `t_re`, `t_im` in W: twiddle, Q(W−FRAC).FRAC.
- `scale` in 1: 1 divides both outputs by 2 with rounding.
- `tag_in` in TAG_W: carried unchanged to `tag_out`.
- `out_valid` out 1: output transaction present.
- `out_ready` in 1: downstream accepts output.
- `x_re`, `x_im`, `y_re`, `y_im` out W: results.
- `tag_out` out TAG_W: tag of the current output.
- `ovf` out 1: qualified by `out_valid`; 1 if any of the four results saturated.

## Operation
- Three register stages (S1, S2, S3), each with a valid bit. S3 drives the outputs directly.
- S1: registers p1 = b_re·t_re, p2 = b_im·t_im, p3 = b_re·t_im and p4 = b_im·t_re, each a full 2W-bit signed product. Also registers A, `scale` and `tag`.
- S2: yR = (p1 − p2 + 2^(FRAC−1)) >>> FRAC and yI = (p3 + p4 + 2^(FRAC−1)) >>> FRAC.
  - Rounding is half toward +∞.
  - Results are kept to W+1 bits. Any excess wraps; the bench never drives |T| > 1.
- S3: sX = A + y and sY = A − y in W+2 bits.
  - If `scale`, each becomes (s + 1) >>> 1.
  - Each is then reduced to W bits (see Configuration).
  - `ovf` = OR of the four per-result overflow conditions.
- Handshake:
  - Global stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - When not stalled, all stages advance. S1 loads on in_valid & in_ready; otherwise S1.valid clears.
  - While stalled, every stage register holds. Outputs, `tag_out` and `ovf` stay stable until accepted.
  - Bubbles do not collapse during a stall.
- Order is strictly preserved. There is no drop and no duplication.

## Timing
- Latency is 3 cycles: input accepted at edge n gives out_valid from edge n+3, absent stalls.
- Throughput is one transaction per cycle with out_ready held high.
- Reset (asynchronous, immediate):
  - All valid bits, data registers, outputs, `tag_out` and `ovf` go to 0.
  - in_ready reads 1 during and after reset.
- Reset mid-operation drops all in-flight transactions. The first output after release comes 3 cycles after the first post-reset accept.
- Input accepted in the same cycle an output is accepted: both happen and the pipe advances.
- out_ready is ignored when out_valid = 0.

## Configuration
- `BUTTERFLY_SAT_EN` defined:
  - Any W+2-bit result outside [−2^(W−1), 2^(W−1)−1] clamps to the nearest bound.
  - The corresponding overflow condition is set.
- `BUTTERFLY_SAT_EN` undefined:
  - Results are truncated to the low W bits (wrap).
  - `ovf` is tied 0; the port remains.

## Structure
- Shared package `fft_pkg` holds:
  - default `W`, `FRAC`, `TAG_W`;
  - typedef `cplx_t` (re/im pair);
  - constant `ONE_Q` = 2^FRAC;
  - function `rnd_shift` (add half, arithmetic shift).
- One sub-module, `fft_sat`: W+2 → W reducer with overflow flag. It contains the `BUTTERFLY_SAT_EN` behaviour and is instantiated four times in S3.

## Test plan
All values use W=16, FRAC=8, with `BUTTERFLY_SAT_EN` defined unless stated otherwise.
1. Identity: A=(0x0100,0), B=(0x0100,0), T=(0x0100,0), scale=0 → X=(0x0200,0), Y=(0,0), ovf=0, 3 cycles after accept.
2. −j twiddle: A=0, B=(0x0100,0x0080), T=(0,0xFF00) → X=(0x0080,0xFF00), Y=(0xFF80,0x0100).
3. Saturation and scaling:
   - A=B=(0x7F00,0), T=1.0, scale=0 → x_re=0x7FFF, y_re=0, ovf=1.
   - Same with scale=1 → x_re=0x7F00, ovf=0.
   - Same with macro undefined, scale=0 → x_re=0xFE00, ovf=0.
4. Rounding: A=0, B=(0x0001,0), T=(0x0080,0) → X=(0x0001,0), Y=(0xFFFF,0).
5. Backpressure: 8 back-to-back inputs with tags 0..7, out_ready low for 3 cycles mid-stream.
   - in_ready is low exactly while stalled.
   - Held outputs are stable.
   - All 8 results emerge in order, with correct tags, none lost.
6. Reset mid-stream: assert rst with 3 transactions in flight.
   - Outputs are 0 and out_valid=0 immediately.
   - After release, no stale output appears.
   - Next accept yields out_valid exactly 3 cycles later.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT datapath.
// Default widths, complex sample type, unit twiddle constant and the
// round-half-up arithmetic shift used by the butterfly.
// Saturation is selected per build with BUTTERFLY_SAT_EN (see fft_sat).
package fft_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_FRAC  = 8;
    localparam int DEF_TAG_W = 8;

    // Twiddle value representing 1.0 at the default fraction width.
    localparam int ONE_Q = 1 << DEF_FRAC;

    typedef struct packed {
        logic signed [DEF_W-1:0] re;
        logic signed [DEF_W-1:0] im;
    } cplx_t;

    // Adds half an output LSB then shifts right arithmetically, so ties
    // round toward +infinity. Wide enough for 2W+1-bit sums at W = 24.
    function automatic logic signed [63:0] rnd_shift(input logic signed [63:0] v,
                                                     input int sh);
        logic signed [63:0] half;
        half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (v + half) >>> sh;
    endfunction

endpackage

// File: rtl/fft_sat.sv
// fft_sat: reduces a W+2-bit signed result to W bits.
// With BUTTERFLY_SAT_EN defined, out-of-range values clamp to the nearest
// W-bit bound and raise ovf. Without it the value wraps (low W bits kept)
// and ovf is constant 0.
module fft_sat
    import fft_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W+1:0] din,
    output logic [W-1:0] dout,
    output logic         ovf
);

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    // Clamp to the representable W-bit range and flag any clamping.
    always_comb begin
        dout = din[W-1:0];
        ovf  = 1'b0;
        if ($signed(din) > MAX_V) begin
            dout = MAX_V[W-1:0];
            ovf  = 1'b1;
        end else if ($signed(din) < MIN_V) begin
            dout = MIN_V[W-1:0];
            ovf  = 1'b1;
        end
    end
`else
    // Guard bits are intentionally discarded in the wrapping build.
    logic unused_hi;
    assign unused_hi = ^din[W+1:W];
    assign dout      = din[W-1:0];
    assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/butterfly_pipe.sv
// butterfly_pipe: three-stage radix-2 DIT butterfly, X = A + B*T, Y = A - B*T.
// S1 multiplies, S2 combines products with rounding, S3 adds/subtracts,
// optionally halves, and reduces to W bits. One global stall freezes every
// stage, so bubbles are preserved and outputs hold until accepted.
// Build option BUTTERFLY_SAT_EN selects saturation (with ovf) over wrap.
module butterfly_pipe
    import fft_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int FRAC  = DEF_FRAC,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_re,
    input  logic [W-1:0]     a_im,
    input  logic [W-1:0]     b_re,
    input  logic [W-1:0]     b_im,
    input  logic [W-1:0]     t_re,
    input  logic [W-1:0]     t_im,
    input  logic             scale,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     x_re,
    output logic [W-1:0]     x_im,
    output logic [W-1:0]     y_re,
    output logic [W-1:0]     y_im,
    output logic [TAG_W-1:0] tag_out,
    output logic             ovf
);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // ---------------- S1: products ----------------
    logic                    s1_valid;
    logic signed [2*W-1:0]   p1, p2, p3, p4;
    logic [W-1:0]            s1_a_re, s1_a_im;
    logic                    s1_scale;
    logic [TAG_W-1:0]        s1_tag;

    // Capture the four partial products plus A, scale and tag on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            p1       <= '0;
            p2       <= '0;
            p3       <= '0;
            p4       <= '0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_scale <= 1'b0;
            s1_tag   <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                p1       <= (2*W)'($signed(b_re)) * (2*W)'($signed(t_re));
                p2       <= (2*W)'($signed(b_im)) * (2*W)'($signed(t_im));
                p3       <= (2*W)'($signed(b_re)) * (2*W)'($signed(t_im));
                p4       <= (2*W)'($signed(b_im)) * (2*W)'($signed(t_re));
                s1_a_re  <= a_re;
                s1_a_im  <= a_im;
                s1_scale <= scale;
                s1_tag   <= tag_in;
            end
        end
    end

    // ---------------- S2: rounded complex product ----------------
    logic signed [63:0] re_sum, im_sum;
    assign re_sum = 64'(p1) - 64'(p2);
    assign im_sum = 64'(p3) + 64'(p4);

    logic                    s2_valid;
    logic signed [W:0]       s2_y_re, s2_y_im;
    logic [W-1:0]            s2_a_re, s2_a_im;
    logic                    s2_scale;
    logic [TAG_W-1:0]        s2_tag;

    // Round B*T back to sample scale; W+1 bits covers |B*T| for |T| <= 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y_re  <= '0;
            s2_y_im  <= '0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
            s2_scale <= 1'b0;
            s2_tag   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y_re  <= (W+1)'(rnd_shift(re_sum, FRAC));
                s2_y_im  <= (W+1)'(rnd_shift(im_sum, FRAC));
                s2_a_re  <= s1_a_re;
                s2_a_im  <= s1_a_im;
                s2_scale <= s1_scale;
                s2_tag   <= s1_tag;
            end
        end
    end

    // ---------------- S3: add/sub, scale, reduce ----------------
    function automatic logic signed [W+1:0] opt_half(input logic signed [W+1:0] s,
                                                     input logic sc);
        return sc ? (W+2)'(rnd_shift(64'(s), 1)) : s;
    endfunction

    logic signed [W+1:0] sx_re, sx_im, sy_re, sy_im;

    // Sums in W+2 bits cannot overflow, so reduction sees the true value.
    always_comb begin
        sx_re = opt_half((W+2)'($signed(s2_a_re)) + (W+2)'(s2_y_re), s2_scale);
        sx_im = opt_half((W+2)'($signed(s2_a_im)) + (W+2)'(s2_y_im), s2_scale);
        sy_re = opt_half((W+2)'($signed(s2_a_re)) - (W+2)'(s2_y_re), s2_scale);
        sy_im = opt_half((W+2)'($signed(s2_a_im)) - (W+2)'(s2_y_im), s2_scale);
    end

    logic [W-1:0] r_x_re, r_x_im, r_y_re, r_y_im;
    logic         o_x_re, o_x_im, o_y_re, o_y_im;

    fft_sat #(.W(W)) u_sat_x_re (.din(sx_re), .dout(r_x_re), .ovf(o_x_re));
    fft_sat #(.W(W)) u_sat_x_im (.din(sx_im), .dout(r_x_im), .ovf(o_x_im));
    fft_sat #(.W(W)) u_sat_y_re (.din(sy_re), .dout(r_y_re), .ovf(o_y_re));
    fft_sat #(.W(W)) u_sat_y_im (.din(sy_im), .dout(r_y_im), .ovf(o_y_im));

    // Output register: holds while stalled so data stays stable until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
            tag_out   <= '0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                x_re    <= r_x_re;
                x_im    <= r_x_im;
                y_re    <= r_y_re;
                y_im    <= r_y_im;
                tag_out <= s2_tag;
                ovf     <= o_x_re | o_x_im | o_y_re | o_y_im;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Testbench for butterfly_pipe (W=16, FRAC=8, TAG_W=8). Expected values
// track BUTTERFLY_SAT_EN so the bench works in either build.
module tb_butterfly_pipe;
    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     a_re = '0, a_im = '0, b_re = '0, b_im = '0, t_re = '0, t_im = '0;
    logic             scale = 1'b0;
    logic [TAG_W-1:0] tag_in = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [W-1:0]     x_re, x_im, y_re, y_im;
    logic [TAG_W-1:0] tag_out;
    logic             ovf;

    butterfly_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .t_re(t_re), .t_im(t_im), .scale(scale), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
        .tag_out(tag_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;

    typedef struct packed {
        logic [W-1:0]     xr, xi, yr, yi;
        logic [TAG_W-1:0] tg;
        logic             ov;
    } res_t;

    res_t exp_q[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint wrap(input longint v, input int bits);
        longint m, r;
        m = longint'(1) <<< bits;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic longint reduce(input longint s, output logic o);
        longint hi, lo;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        o = 1'b0;
`ifdef BUTTERFLY_SAT_EN
        if (s > hi) begin o = 1'b1; return hi; end
        if (s < lo) begin o = 1'b1; return lo; end
        return s;
`else
        if (s > hi || s < lo) return wrap(s, W);
        return s;
`endif
    endfunction

    function automatic res_t model(input logic [W-1:0] ar, ai, br, bi, tr, ti,
                                   input logic sc, input logic [TAG_W-1:0] tg);
        longint a_r, a_i, b_r, b_i, w_r, w_i, yr, yi, s[4];
        logic   o[4];
        res_t   r;
        a_r = $signed(ar); a_i = $signed(ai);
        b_r = $signed(br); b_i = $signed(bi);
        w_r = $signed(tr); w_i = $signed(ti);
        // floor((v + 0.5 LSB) / 2^FRAC) is round-half-up
        yr = wrap((b_r * w_r - b_i * w_i + (longint'(1) <<< (FRAC - 1))) >>> FRAC, W + 1);
        yi = wrap((b_r * w_i + b_i * w_r + (longint'(1) <<< (FRAC - 1))) >>> FRAC, W + 1);
        s[0] = a_r + yr; s[1] = a_i + yi; s[2] = a_r - yr; s[3] = a_i - yi;
        for (int k = 0; k < 4; k++) begin
            if (sc) s[k] = (s[k] + 1) >>> 1;
            s[k] = reduce(s[k], o[k]);
        end
        r.xr = W'(s[0]); r.xi = W'(s[1]); r.yr = W'(s[2]); r.yi = W'(s[3]);
        r.tg = tg;
        r.ov = o[0] | o[1] | o[2] | o[3];
        return r;
    endfunction

    // ---------------- compare process ----------------
    logic have_prev = 1'b0;
    res_t prev_out;

    always @(negedge clk) begin
        res_t cur, e;
        cur = '{xr: x_re, xi: x_im, yr: y_re, yi: y_im, tg: tag_out, ov: ovf};
        if (rst) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (have_prev) begin
                check("held_valid", 64'(out_valid), 64'd1);
                check("held_data", 64'(cur), 64'(prev_out));
            end
            have_prev = out_valid && !out_ready;
            prev_out  = cur;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("model_out", 64'(cur), 64'(e));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(a_re, a_im, b_re, b_im, t_re, t_im, scale, tag_in));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [W-1:0] ar, ai, br, bi, tr, ti,
                         input logic sc, input logic [TAG_W-1:0] tg);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; t_re = tr; t_im = ti;
        scale = sc; tag_in = tg; in_valid = 1'b1;
    endtask

    // Single transaction into an idle pipe; checks latency and literal results.
    task automatic run_one(input string nm, input logic [W-1:0] ar, ai, br, bi, tr, ti,
                           input logic sc, input logic [TAG_W-1:0] tg,
                           input logic [W-1:0] exr, exi, eyr, eyi, input logic eov);
        int cnt;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(ar, ai, br, bi, tr, ti, sc, tg);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 12) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({nm, ".latency"}, 64'(cnt), 64'd3);
        check({nm, ".x_re"}, 64'(x_re), 64'(exr));
        check({nm, ".x_im"}, 64'(x_im), 64'(exi));
        check({nm, ".y_re"}, 64'(y_re), 64'(eyr));
        check({nm, ".y_im"}, 64'(y_im), 64'(eyi));
        check({nm, ".tag"}, 64'(tag_out), 64'(tg));
        check({nm, ".ovf"}, 64'(ovf), 64'(eov));
    endtask

    logic [W-1:0] tw_re[4] = '{16'h0100, 16'h00B5, 16'h0000, 16'hFF4B};
    logic [W-1:0] tw_im[4] = '{16'h0000, 16'hFF4B, 16'hFF00, 16'h00B5};

    initial begin
        int cnt, target;
        logic seen;

        #3 rst = 1'b1;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.outputs", 64'({x_re, x_im, y_re, y_im, tag_out, ovf}), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        run_one("identity", 16'h0100, 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b0, 8'h11,
                16'h0200, 16'h0, 16'h0, 16'h0, 1'b0);
        run_one("minus_j", 16'h0, 16'h0, 16'h0100, 16'h0080, 16'h0, 16'hFF00, 1'b0, 8'h22,
                16'h0080, 16'hFF00, 16'hFF80, 16'h0100, 1'b0);
`ifdef BUTTERFLY_SAT_EN
        run_one("sat", 16'h7F00, 16'h0, 16'h7F00, 16'h0, 16'h0100, 16'h0, 1'b0, 8'h33,
                16'h7FFF, 16'h0, 16'h0, 16'h0, 1'b1);
`else
        run_one("wrap", 16'h7F00, 16'h0, 16'h7F00, 16'h0, 16'h0100, 16'h0, 1'b0, 8'h33,
                16'hFE00, 16'h0, 16'h0, 16'h0, 1'b0);
`endif
        run_one("scaled", 16'h7F00, 16'h0, 16'h7F00, 16'h0, 16'h0100, 16'h0, 1'b1, 8'h44,
                16'h7F00, 16'h0, 16'h0, 16'h0, 1'b0);
        run_one("round", 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0080, 16'h0, 1'b0, 8'h55,
                16'h0001, 16'h0, 16'hFFFF, 16'h0, 1'b0);
        // scale of -3: (-3+1)>>>1 = -1 for X, Y = (0+3+1)>>>1 = 2 ... A=0,B=(3,0),T=1.0
        run_one("scale_neg", 16'h0, 16'h0, 16'hFFFD, 16'h0, 16'h0100, 16'h0, 1'b1, 8'h66,
                16'hFFFF, 16'h0, 16'h0002, 16'h0, 1'b0);

        // Backpressure: 8 back-to-back transactions, out_ready low 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        target = n_out + 8;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   tries;
                    drive(16'(i * 'h0300 - 'h0A00), 16'(i * 'h0040),
                          16'('h0200 + i * 'h0111), 16'(-(i * 'h0050)),
                          tw_re[i % 4], tw_im[i % 4], 1'(i % 2), 8'(i));
                    tries = 0;
                    acc   = 1'b0;
                    while (!acc && tries < 20) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        tries++;
                    end
                    if (!acc) check("bp.accept_timeout", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        cnt = 0;
        while (n_out < target && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("bp.count", 64'(n_out), 64'(target));

        // Reset with three transactions in flight.
        @(posedge clk); #1;
        drive(16'h0100, 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b0, 8'hA0);
        @(posedge clk); #1;
        tag_in = 8'hA1;
        @(posedge clk); #1;
        tag_in = 8'hA2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("pre_rst.out_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst.out_valid", 64'(out_valid), 64'd0);
        check("mid_rst.outputs", 64'({x_re, x_im, y_re, y_im, tag_out, ovf}), 64'd0);
        check("mid_rst.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("post_rst.stale", 64'(seen), 64'd0);
        run_one("post_rst", 16'h0100, 16'h0, 16'h0100, 16'h0, 16'h0100, 16'h0, 1'b0, 8'h77,
                16'h0200, 16'h0, 16'h0, 16'h0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
